// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_compute.sv
// Combinational MULT/DIV datapath producing the 64-bit {hi,lo} result.
module md_compute
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [31:0] sa32;
  logic signed [31:0] sb32;
  logic [63:0]        prod_u;
  logic [63:0]        prod_s;

  assign sa64   = {{32{a[31]}}, a};
  assign sb64   = {{32{b[31]}}, b};
  assign sa32   = a;
  assign sb32   = b;
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (md_op_e'(op))
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        if (b == '0) begin
          div_zero = 1'b1;
        end else if (a == 32'h8000_0000 && b == '1) begin
          // Quotient overflows 32 bits; pin it to the most negative value.
          result = {32'd0, 32'h8000_0000};
        end else begin
          result = {32'(sa32 % sb32), 32'(sa32 / sb32)};
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          div_zero = 1'b1;
        end else begin
          result = {a % b, a / b};
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO owner: latches MULT/DIV results at start, counts down latency, then commits.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [63:0]        pend, pend_n;
  logic               pend_dz, pend_dz_n;
  logic [31:0]        hi_n, lo_n;
  logic               done_n;
  logic [63:0]        result;
  logic               div_zero;

  md_compute u_compute (
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pend    <= pend_n;
      pend_dz <= pend_dz_n;
      hi      <= hi_n;
      lo      <= lo_n;
      done    <= done_n;
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    state_n   = state;
    count_n   = count;
    pend_n    = pend;
    pend_dz_n = pend_dz;
    hi_n      = hi;
    lo_n      = lo;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op_e'(op))
            MD_MULT, MD_MULTU: begin
              pend_n    = result;
              pend_dz_n = 1'b0;
              count_n   = CNT_W'(MULT_CYCLES);
              state_n   = RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_n    = result;
              pend_dz_n = div_zero;
              count_n   = CNT_W'(DIV_CYCLES);
              state_n   = RUN;
            end
            MD_MTHI: hi_n = a;
            MD_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Commit on the edge that sees count==1 so busy spans exactly N cycles.
        if (count == CNT_W'(1)) begin
          state_n = IDLE;
          count_n = '0;
          done_n  = 1'b1;
          if (!pend_dz) begin
            hi_n = pend[63:32];
            lo_n = pend[31:0];
          end
        end else begin
          count_n = count - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
